// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard/stall controller slice.
package hazard_stall_ctrl_pkg;

  // Register index width (MIPS GPR file).
  localparam int REG_W = 5;

  // Tuse / Tnew encoding: cycles until a value is needed / produced.
  localparam int T_W = 2;
  typedef logic [T_W-1:0] t_time;

  // Tuse value meaning "this source register is not read".
  localparam t_time TUSE_NONE = 2'd3;

  // Mult/div sequencer state encoding.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Default mult/div latencies (busy cycles after the start cycle).
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_fsm.sv
// Mult/div occupancy sequencer: IDLE/BUSY FSM plus a down-counter.
// The busy flag is combinational so the start cycle itself reads as busy.
module md_busy_fsm
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4   // must be wide enough to hold DIV_CYC
) (
  input  logic      clk,
  input  logic      i_rst_n,
  input  logic      i_md_start,
  input  logic      i_md_is_div,
  output logic      o_md_busy,
  output md_state_e o_state
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;

  assign w_load = i_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

  // FSM and counter: a start (legal or not) always reloads; BUSY ends on the
  // edge where the counter steps from 1 to 0.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_md_start) begin
            r_state <= MD_BUSY;
            r_cnt   <= w_load;
          end
        end
        MD_BUSY: begin
          if (i_md_start) begin
            r_cnt <= w_load;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_md_busy = i_rst_n & (i_md_start | (r_state == MD_BUSY));
  assign o_state   = r_state;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Stall = D-stage data hazard against E/M producers, or an MD instruction in
// D while the mult/div unit is occupied. One stall drives stop, hold_D and
// flush_E on the same cycle.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,        // synchronous, active-low
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  t_time            tuse_rs_D,
  input  t_time            tuse_rt_D,
  input  logic             md_use_D,
  input  logic [REG_W-1:0] dst_E,
  input  t_time            tnew_E,
  input  logic [REG_W-1:0] dst_M,
  input  t_time            tnew_M,
  input  logic             md_start_E,
  input  logic             md_is_div_E,
  output logic             stop,
  output logic             hold_D,
  output logic             flush_E,
  output logic             md_busy,
  output logic [31:0]      stall_cnt
);

  logic      w_rs_used;
  logic      w_rt_used;
  logic      w_stall_rs;
  logic      w_stall_rt;
  logic      w_stall_md;
  logic      w_stall;
  logic      w_md_busy;
  md_state_e w_md_state;
  logic [31:0] r_stall_cnt;

  md_busy_fsm #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy_fsm (
    .clk         (clk),
    .i_rst_n     (reset),
    .i_md_start  (md_start_E),
    .i_md_is_div (md_is_div_E),
    .o_md_busy   (w_md_busy),
    .o_state     (w_md_state)
  );

  // A source with Tuse == TUSE_NONE can never be less than any Tnew, but the
  // explicit gate documents that unused sources never stall.
  assign w_rs_used = (tuse_rs_D != TUSE_NONE);
  assign w_rt_used = (tuse_rt_D != TUSE_NONE);

  // Stall only when the producer is too late for forwarding (Tuse < Tnew);
  // $0 is hard-wired and never creates a dependence.
  assign w_stall_rs = w_rs_used && (rs_D != '0) &&
                      (((rs_D == dst_E) && (tuse_rs_D < tnew_E)) ||
                       ((rs_D == dst_M) && (tuse_rs_D < tnew_M)));
  assign w_stall_rt = w_rt_used && (rt_D != '0) &&
                      (((rt_D == dst_E) && (tuse_rt_D < tnew_E)) ||
                       ((rt_D == dst_M) && (tuse_rt_D < tnew_M)));
  assign w_stall_md = md_use_D && w_md_busy;

  assign w_stall = reset & (w_stall_rs | w_stall_rt | w_stall_md);

  assign stop      = w_stall;
  assign hold_D    = w_stall;
  assign flush_E   = w_stall;
  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

  // Performance counter: one count per stalled cycle, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Whenever the sequencer sits in BUSY, the unit must report busy.
  a_busy_state : assert property (@(posedge clk) disable iff (!reset)
    (w_md_state == MD_BUSY) |-> md_busy);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: table of single-cycle hazard
// vectors, hand-written multi-cycle sequences, then random traffic compared
// against a cycle-index-based reference model.
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  rs_D, rt_D, dst_E, dst_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_use_D, md_start_E, md_is_div_E;
  logic        stop, hold_D, flush_E, md_busy;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .tuse_rs_D   (tuse_rs_D),
    .tuse_rt_D   (tuse_rt_D),
    .md_use_D    (md_use_D),
    .dst_E       (dst_E),
    .tnew_E      (tnew_E),
    .dst_M       (dst_M),
    .tnew_M      (tnew_M),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .stop        (stop),
    .hold_D      (hold_D),
    .flush_E     (flush_E),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc        = 0;   // index of the current cycle
  int busy_until = 0;   // unit is busy in every cycle with index < busy_until
  logic [31:0] m_cnt = '0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic hz(input logic [4:0] src, input logic [1:0] tuse,
                              input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 0) && (src == dst) && (int'(tuse) < int'(tnew));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3; md_use_D = 0;
    dst_E = 0; tnew_E = 0; dst_M = 0; tnew_M = 0;
    md_start_E = 0; md_is_div_E = 0;
  endtask

  // Called just after a negedge with inputs applied: compare the whole output
  // set against the model, then advance the model across the next posedge.
  task automatic tick();
    logic data_hz, e_busy, e_stall;
    #1;
    data_hz = hz(rs_D, tuse_rs_D, dst_E, tnew_E) | hz(rs_D, tuse_rs_D, dst_M, tnew_M) |
              hz(rt_D, tuse_rt_D, dst_E, tnew_E) | hz(rt_D, tuse_rt_D, dst_M, tnew_M);
    e_busy  = reset && (md_start_E || (cyc < busy_until));
    e_stall = reset && (data_hz || (md_use_D && e_busy));
    exp_q.push_back(m_cnt);
    check("stop",    {31'b0, stop},    {31'b0, e_stall});
    check("hold_D",  {31'b0, hold_D},  {31'b0, e_stall});
    check("flush_E", {31'b0, flush_E}, {31'b0, e_stall});
    check("md_busy", {31'b0, md_busy}, {31'b0, e_busy});
    check("stall_cnt", stall_cnt, exp_q.pop_front());
    if (!reset) begin
      m_cnt = '0;
      busy_until = 0;
    end else begin
      if (e_stall) m_cnt = m_cnt + 32'd1;
      if (md_start_E) busy_until = cyc + 1 + (md_is_div_E ? DIV_N : MULT_N);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle(); reset = 1'b0; tick();
    @(negedge clk); reset = 1'b1; tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs; logic [4:0] rt; logic [1:0] tu_rs; logic [1:0] tu_rt;
    logic [4:0] de; logic [1:0] te; logic [4:0] dm; logic [1:0] tm;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // rs   rt  tu_rs tu_rt  de te  dm tm  stall
    vecs[0]  = '{5'd8,  5'd0, 2'd1, 2'd3, 5'd8,  2'd2, 5'd0,  2'd0, 1'b1}; // load-use rs vs E
    vecs[1]  = '{5'd0,  5'd0, 2'd0, 2'd3, 5'd0,  2'd2, 5'd0,  2'd0, 1'b0}; // $0 never stalls
    vecs[2]  = '{5'd1,  5'd9, 2'd3, 2'd3, 5'd9,  2'd2, 5'd0,  2'd0, 1'b0}; // rt unused
    vecs[3]  = '{5'd1,  5'd9, 2'd3, 2'd0, 5'd9,  2'd1, 5'd0,  2'd0, 1'b1}; // rt vs E, 0<1
    vecs[4]  = '{5'd4,  5'd0, 2'd1, 2'd3, 5'd0,  2'd0, 5'd4,  2'd1, 1'b0}; // tuse==tnew: forward
    vecs[5]  = '{5'd4,  5'd0, 2'd0, 2'd3, 5'd0,  2'd0, 5'd4,  2'd1, 1'b1}; // rs vs M, 0<1
    vecs[6]  = '{5'd7,  5'd7, 2'd2, 2'd2, 5'd7,  2'd2, 5'd7,  2'd1, 1'b0}; // all forwardable
    vecs[7]  = '{5'd7,  5'd3, 2'd2, 2'd1, 5'd3,  2'd2, 5'd0,  2'd0, 1'b1}; // rt vs E, 1<2
    vecs[8]  = '{5'd31, 5'd0, 2'd0, 2'd3, 5'd30, 2'd3, 5'd29, 2'd3, 1'b0}; // no match
    vecs[9]  = '{5'd31, 5'd0, 2'd2, 2'd3, 5'd31, 2'd3, 5'd0,  2'd0, 1'b1}; // 2<3
    vecs[10] = '{5'd0,  5'd0, 2'd0, 2'd0, 5'd0,  2'd3, 5'd0,  2'd3, 1'b0}; // $0 both
    vecs[11] = '{5'd5,  5'd6, 2'd3, 2'd3, 5'd5,  2'd3, 5'd6,  2'd3, 1'b0}; // both unused
  end

  // ---------------- main sequence ----------------
  initial begin
    set_idle();
    reset = 1'b0;
    @(posedge clk);
    // reset state
    @(negedge clk); tick();
    check("rst_cnt", stall_cnt, 32'd0);
    check("rst_busy", {31'b0, md_busy}, 32'd0);
    @(negedge clk); reset = 1'b1; tick();

    // table-driven hazard vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_idle();
      rs_D = vecs[i].rs; rt_D = vecs[i].rt;
      tuse_rs_D = vecs[i].tu_rs; tuse_rt_D = vecs[i].tu_rt;
      dst_E = vecs[i].de; tnew_E = vecs[i].te;
      dst_M = vecs[i].dm; tnew_M = vecs[i].tm;
      tick();
      check($sformatf("vec%0d_stop", i), {31'b0, stop}, {31'b0, vecs[i].exp_stall});
    end

    // 1. load-use then resolved in M
    do_reset();
    @(negedge clk); set_idle();
    dst_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1; tick();
    check("t1_stall", {29'b0, stop, hold_D, flush_E}, 32'd7);
    @(negedge clk); set_idle();
    rs_D = 8; tuse_rs_D = 1; dst_M = 8; tnew_M = 1; tick();
    check("t1_resolved", {31'b0, stop}, 32'd0);
    check("t1_cnt", stall_cnt, 32'd1);

    // 3. mult with mflo waiting in D
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk); set_idle();
      md_use_D = 1; md_start_E = (k == 0);
      tick();
      check($sformatf("t3_busy%0d", k), {31'b0, md_busy}, {31'b0, k <= 5});
      check($sformatf("t3_stop%0d", k), {31'b0, stop}, {31'b0, k <= 5});
    end
    check("t3_cnt", stall_cnt, 32'd6);

    // 4. div, non-MD instruction in D does not stall
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk); set_idle();
      rs_D = 3; tuse_rs_D = 1; md_start_E = (k == 0); md_is_div_E = (k == 0);
      tick();
      check($sformatf("t4_busy%0d", k), {31'b0, md_busy}, {31'b0, k <= 10});
      check($sformatf("t4_stop%0d", k), {31'b0, stop}, 32'd0);
    end

    // 5. reset in the middle of a div
    do_reset();
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk); set_idle();
      md_use_D = 1; md_start_E = (k == 0); md_is_div_E = 1; tick();
    end
    check("t5_precnt", stall_cnt, 32'd2);
    @(negedge clk); set_idle(); md_use_D = 1; reset = 1'b0; tick();
    check("t5_rst_busy", {31'b0, md_busy}, 32'd0);
    check("t5_rst_stop", {31'b0, stop}, 32'd0);
    @(negedge clk); set_idle(); md_use_D = 1; reset = 1'b1; tick();
    check("t5_idle_busy", {31'b0, md_busy}, 32'd0);
    check("t5_idle_stop", {31'b0, stop}, 32'd0);
    check("t5_cnt", stall_cnt, 32'd0);

    // 6. data hazard and MD stall together count once per cycle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_idle();
      md_use_D = 1; md_start_E = (k == 0);
      rs_D = 8; tuse_rs_D = 0; dst_E = 8; tnew_E = 2;
      tick();
    end
    @(negedge clk); set_idle(); tick();
    check("t6_cnt", stall_cnt, 32'd3);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      tuse_rs_D = 2'($urandom_range(0, 3)); tuse_rt_D = 2'($urandom_range(0, 3));
      dst_E = 5'($urandom_range(0, 3)); tnew_E = 2'($urandom_range(0, 3));
      dst_M = 5'($urandom_range(0, 3)); tnew_M = 2'($urandom_range(0, 3));
      md_use_D = ($urandom_range(0, 2) == 0);
      md_start_E = ($urandom_range(0, 9) == 0);
      md_is_div_E = $urandom_range(0, 1) == 1;
      reset = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
